// File: rtl/line_buf_reader_if.sv
// RAM read port and byte stream of the line buffer reader.
// The master side is the reader; the slave side is the RAM plus downstream stage.
interface line_buf_reader_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
);
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    output ram_re, ram_raddr, m_data, m_valid, m_last,
    input  ram_rdata, m_ready
  );

  modport slave (
    input  ram_re, ram_raddr, m_data, m_valid, m_last,
    output ram_rdata, m_ready
  );
endinterface

// File: rtl/line_buf_reader.sv
// Line buffer read controller: fetches line_len bytes from base_addr (with wrap) and streams
// them out. A 2-entry skid FIFO plus the arriving RAM word cover the 1-cycle read latency.
module line_buf_reader #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      line_len,
  output logic                 busy,
  output logic                 done,
  line_buf_reader_if.master    bus
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  localparam logic [ADDR_W:0] One = {{ADDR_W{1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [ADDR_W:0]          rem_q, rem_d;
  logic [ADDR_W:0]          len_q, len_d;
  logic [ADDR_W:0]          beat_q, beat_d;
  logic [1:0]               cnt_q, cnt_d, cnt_mid;
  logic                     inflight_q, inflight_d;
  logic                     done_q, done_d;
  logic [1:0][DATA_W-1:0]   mem_q, mem_d;

  logic                     valid, pop, issue, pop_fifo, push;
  logic [DATA_W-1:0]        head;

  // The word returning from the RAM counts as an entry in the cycle it appears.
  assign valid = (cnt_q != 2'd0) | inflight_q;
  assign head  = (cnt_q != 2'd0) ? mem_q[0] : bus.ram_rdata;
  assign pop   = valid & bus.m_ready;
  assign issue = (state_q == StRead) &&
                 (({1'b0, cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  assign pop_fifo = pop & (cnt_q != 2'd0);
  assign push     = inflight_q & ~(pop & (cnt_q == 2'd0));

  assign bus.m_valid   = valid;
  assign bus.m_data    = valid ? head : '0;
  assign bus.m_last    = valid & (beat_q == (len_q - One));
  assign bus.ram_re    = issue;
  assign bus.ram_raddr = addr_q;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;

  always_comb begin
    mem_d   = mem_q;
    cnt_mid = cnt_q;
    if (pop_fifo) begin
      mem_d[0] = mem_q[1];
      cnt_mid  = cnt_q - 2'd1;
    end
    if (push) begin
      mem_d[cnt_mid[0]] = bus.ram_rdata;
    end
    cnt_d = cnt_mid + {1'b0, push};
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    len_d      = len_q;
    beat_d     = beat_q + {{ADDR_W{1'b0}}, pop};
    inflight_d = issue;
    done_d     = 1'b0;

    if (issue) begin
      addr_d = addr_q + 1'b1;
      rem_d  = rem_q - One;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (line_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = base_addr;
            rem_d   = line_len;
            len_d   = line_len;
            beat_d  = '0;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (issue && (rem_q == One)) state_d = StDrain;
      end
      StDrain: begin
        // Finish as soon as the last beat is handshaken so done lands on the following cycle.
        if (cnt_d == 2'd0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      mem_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: doc/line_buf_reader.md
# line_buf_reader

Read-side controller for the 512x8 pseudo-dual-port line buffer in the YCbCr-to-RGB frame-buffer path. On a start command it fetches `line_len` bytes from the RAM read port, beginning at `base_addr` with modulo-512 wrap. It presents them as a valid/ready byte stream to the colour-conversion stage. A 2-entry skid FIFO absorbs the RAM's one-cycle registered read latency, so downstream backpressure never drops or duplicates a byte.

## Interface
Parameters:
- `ADDR_W`, 9, RAM address width; depth is 2^ADDR_W.
- `DATA_W`, 8, RAM and stream data width.

Ports:
- `clk` in 1: single clock, shared with the RAM `rclk`.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle command; sampled only in IDLE.
- `base_addr` in ADDR_W: first read address, captured with `start`.
- `line_len` in ADDR_W+1: byte count, 0..512, captured with `start`.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle pulse at command completion.
- `ram_re` out 1: RAM read enable.
- `ram_raddr` out ADDR_W: RAM read address.
- `ram_rdata` in DATA_W: RAM read data, valid the cycle after `ram_re`.
- `m_data` out DATA_W: stream data.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: stream ready.
- `m_last` out 1: marks the final byte of the line.

## Operation
- FSM states: IDLE, READ, DRAIN.
- **IDLE**
  - On `start` with `line_len`=0: go to DONE behaviour directly, i.e. pulse `done` in the next cycle with no beats and no RAM reads. `busy` stays 0.
  - On `start` with `line_len`>0: latch the address and the remaining-issue count, set `busy`=1, go to READ.
- **READ**: issue one read per cycle while credit is available.
  - Credit rule: `fifo_count + inflight - pop < 2`, where `pop` = `m_valid & m_ready` this cycle.
  - Each issue drives `ram_re`=1 with `ram_raddr`=current address, then increments the address modulo 2^ADDR_W (511 wraps to 0) and decrements the issue count.
  - When the issue count reaches 0, go to DRAIN.
- **DRAIN**: no further reads.
  - When the FIFO is empty and there is no inflight read, pulse `done`, clear `busy`, return to IDLE.
- **FIFO**
  - `ram_rdata` is pushed on the cycle after an issue.
  - The head drives `m_data`/`m_valid`.
  - Simultaneous push and pop are allowed; the count is unchanged.
  - Overflow is impossible by the credit rule.
- **`m_last`**: high with the head entry when it is the `line_len`-th byte (a delivered-beat counter equals `line_len`-1). It is held with the data while stalled.
- **Stream rules**: `m_data` and `m_last` are stable while `m_valid`=1 and `m_ready`=0. `m_valid` never drops without a handshake.
- **`start` while `busy`**: ignored; it does not affect the current command.
- **`ram_re`** is 0 whenever no issue occurs. `ram_raddr` holds its last value when idle.
- **`rst` mid-command**:
  - On the next edge, go to IDLE, flush the FIFO, discard the inflight read.
  - All outputs take their reset values; no `done` pulse is produced.
- **Reset values**: `busy`=0, `done`=0, `ram_re`=0, `ram_raddr`=0, `m_valid`=0, `m_last`=0, `m_data`=0.

## Timing
- `start` sampled at edge E0.
- `ram_re`=1 with `ram_raddr`=`base_addr` in the cycle after E0.
- Data is pushed at the following edge; `m_valid` first rises 2 cycles after the `start` cycle.
- Throughput is 1 byte/cycle when `m_ready` is held high.
- `done` asserts the cycle after the `m_last` handshake, and `busy` falls in that same cycle.
- Full 512-byte line with `m_ready`=1: `done` arrives 514 cycles after `start`.
- `line_len`=0: `done` arrives 1 cycle after `start`.
- With `m_ready`=0 the reader stalls after at most 2 issued reads: 2 buffered, 0 inflight.

## Test plan
- `base_addr`=0, `line_len`=16, `m_ready`=1, RAM preloaded with addr[7:0]:
  - Bytes 0x00..0x0F arrive on consecutive cycles.
  - `m_last` is set on 0x0F.
  - `done` comes 18 cycles after `start`.
- `base_addr`=510, `line_len`=4: reads occur at addresses 510, 511, 0, 1; the stream is 0xFE, 0xFF, 0x00, 0x01.
- `line_len`=32 with `m_ready` random at 50%:
  - All 32 bytes are delivered in order, with no duplicates.
  - There are never more than 2 outstanding reads plus buffered entries.
  - Data stays stable during stalls.
- `line_len`=0: a single `done` pulse 1 cycle after `start`, with no `ram_re` and no `m_valid`.
- `start` pulsed again mid-line: it is ignored and the original line completes unchanged.
- `rst` asserted after 5 beats of a 64-byte line:
  - All outputs are at their reset values the next cycle, with no `done`.
  - A new `start` then delivers a correct line.
